// File: rtl/diaosi_types_pkg.sv
// rtl/diaosi_types_pkg.sv - shared pipeline types for the fetch stage and its neighbours
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } PCSrc_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_FETCH = 2'b00;
  localparam fetch_state_t S_REDIR = 2'b01;
  localparam fetch_state_t S_HALT  = 2'b10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - bundle of fetch-stage signals seen by the hazard unit and bench
interface fetch_stage_if;
  logic                     pc_en;
  logic                     flushed;
  logic                     id_en;
  diaosi_types_pkg::PCSrc_t pc_src;
  logic [31:0]              branch_addr;
  logic [31:0]              jr_addr;
  logic                     halt;
  logic                     ihit;
  logic [31:0]              imemload;
  logic                     imemREN;
  logic [31:0]              imemaddr;
  logic [31:0]              instr_if_id;
  logic [31:0]              pc_if_id;
  logic [31:0]              npc_if_id;
  logic                     valid_if_id;

  modport fs (
    input  pc_en, flushed, id_en, pc_src, branch_addr, jr_addr, halt, ihit, imemload,
    output imemREN, imemaddr, instr_if_id, pc_if_id, npc_if_id, valid_if_id
  );

  modport tb (
    output pc_en, flushed, id_en, pc_src, branch_addr, jr_addr, halt, ihit, imemload,
    input  imemREN, imemaddr, instr_if_id, pc_if_id, npc_if_id, valid_if_id
  );
endinterface

// File: rtl/fetch_stage_if_id_latch.sv
// rtl/fetch_stage_if_id_latch.sv - IF/ID register with flush, stall and bubble insertion
module if_id_latch
  import diaosi_types_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   flushed,
  input  logic   id_en,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // Flush beats a stall so a squashed instruction never lingers in decode.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= '0;
    end else if (flushed) begin
      q <= '0;
    end else if (id_en) begin
      q <= load ? d : '0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC/next-PC FSM with icache request and IF/ID register
module fetch_stage
  import diaosi_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic        flushed,
  input  logic        id_en,
  input  PCSrc_t      pc_src,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_if_id,
  output logic [31:0] pc_if_id,
  output logic [31:0] npc_if_id,
  output logic        valid_if_id
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  redir_pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  logic         load;
  if_id_t       if_id_d;
  if_id_t       if_id_q;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = pc_en && (pc_src != PC_NEXT);

  always_comb begin
    target = pc_plus4;
    case (pc_src)
      PC_NEXT:   target = pc_plus4;
      PC_BRANCH: target = branch_addr;
      PC_JUMP:   target = {if_id_q.npc[31:28], if_id_q.instr[25:0], 2'b00};
      PC_JR:     target = jr_addr;
      default:   target = pc_plus4;
    endcase
  end

  // A redirect seen during a miss is parked in redir_pc; the address stays put
  // until the icache answers, and that late instruction is thrown away.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= S_FETCH;
      pc       <= PC_INIT;
      redir_pc <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (halt) begin
            state <= S_HALT;
          end else if (redirect) begin
            if (ihit) begin
              pc <= target;
            end else begin
              redir_pc <= target;
              state    <= S_REDIR;
            end
          end else if (pc_en && ihit) begin
            pc <= pc_plus4;
          end
        end
        S_REDIR: begin
          if (halt) begin
            state <= S_HALT;
          end else if (ihit) begin
            pc    <= redirect ? target : redir_pc;
            state <= S_FETCH;
          end else if (redirect) begin
            redir_pc <= target;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  assign imemREN  = (state != S_HALT);
  assign imemaddr = pc;
  assign load     = (state == S_FETCH) && ihit && !halt;
  assign if_id_d  = '{instr: imemload, pc: pc, npc: pc_plus4, valid: 1'b1};

  if_id_latch u_if_id (
    .CLK     (CLK),
    .nRST    (nRST),
    .flushed (flushed),
    .id_en   (id_en),
    .load    (load),
    .d       (if_id_d),
    .q       (if_id_q)
  );

  assign instr_if_id = if_id_q.instr;
  assign pc_if_id    = if_id_q.pc;
  assign npc_if_id   = if_id_q.npc;
  assign valid_if_id = if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipeline.
- Owns the PC and next-PC selection, and drives the icache request (imemREN/imemaddr).
- Consumes the hazard unit's control outputs: pc_en, flush and IF/ID enable.
- Feeds the decode stage through the IF/ID register.
- Handles branch/jump redirects that arrive while an icache miss is outstanding.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- pc_en  input  1  hazard-unit PC update enable
- flushed  input  1  hazard-unit IF/ID flush (inserts bubble)
- id_en  input  1  hazard-unit IF/ID write enable
- pc_src  input  PCSrc_t  next-PC select from hazard unit/decode
- branch_addr  input  32  resolved branch target
- jr_addr  input  32  register value for JR
- halt  input  1  halt retired; stop fetching
- ihit  input  1  icache hit/ready for current imemaddr
- imemload  input  32  instruction from icache
- imemREN  output  1  icache read request
- imemaddr  output  32  icache address (current PC)
- instr_if_id  output  32  IF/ID instruction
- pc_if_id  output  32  IF/ID PC of that instruction
- npc_if_id  output  32  IF/ID PC+4
- valid_if_id  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_INIT, state=S_FETCH, redir_pc=0.
  - instr/pc/npc_if_id=0, valid_if_id=0.
  - imemREN=1 from the first cycle after reset release.
- Outputs:
  - imemaddr=pc always.
  - imemREN=1 in S_FETCH and S_REDIR, 0 in S_HALT.
  - imemaddr must not change while imemREN=1 and ihit=0.
- Target mux (pc_src):
  - PC_NEXT: pc+4.
  - PC_BRANCH: branch_addr.
  - PC_JUMP: {npc_if_id[31:28], instr_if_id[25:0], 2'b00}.
  - PC_JR: jr_addr.
  - All 32-bit; pc+4 wraps modulo 2^32.
- redirect = pc_en && pc_src!=PC_NEXT.
- State S_FETCH:
  - halt -> S_HALT.
  - redirect && ihit -> pc<=target, stay.
  - redirect && !ihit -> redir_pc<=target, pc held, -> S_REDIR.
  - pc_en && ihit && pc_src==PC_NEXT -> pc<=pc+4.
  - Otherwise hold pc.
- State S_REDIR:
  - halt -> S_HALT.
  - A new redirect overwrites redir_pc (newest wins).
  - ihit -> pc<=redir_pc (or the new target if a redirect is in the same cycle), -> S_FETCH; the returning instruction is discarded.
- State S_HALT:
  - pc frozen, imemREN=0.
  - Exit only by reset.
- IF/ID register, priority order:
  1. flushed=1 -> instr=0, valid=0 (pc/npc don't care, cleared to 0). Flush overrides !id_en.
  2. id_en=0 -> hold all fields.
  3. Load real instruction (instr=imemload, pc_if_id=pc, npc_if_id=pc+4, valid=1) only when state==S_FETCH, ihit=1, halt=0.
  4. Otherwise load a bubble (all zero, valid=0). This includes S_REDIR and S_HALT.
- Simultaneous flushed and redirect (normal taken branch): the PC redirect is applied and IF/ID is bubbled in the same edge.
- The fetched instruction is visible at the IF/ID output one cycle after ihit.

Decomposition:
- PCSrc_t lives in diaosi_types_pkg: PC_NEXT=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_JR=2'b11.
- fetch_state_t (S_FETCH, S_REDIR, S_HALT) lives in diaosi_types_pkg.
- Add an if_id_t packed struct (instr, pc, npc, valid) to diaosi_types_pkg.
- A fetch_stage_if interface with modports fs/tb mirrors the hazard-unit interface style.
- One natural sub-module: if_id_latch (the flush/enable/bubble register). The PC FSM stays in fetch_stage.

Test Plan:
- Reset then ihit=1 every cycle, pc_en=1, id_en=1, PC_NEXT -> imemaddr 0,4,8,C on successive cycles; instr_if_id follows imemload one cycle later with valid=1.
- ihit=0 for 3 cycles at pc=0x10 -> imemaddr held at 0x10, pc unchanged, IF/ID bubbles with valid=0; ihit=1 -> pc=0x14.
- At pc=0x20 with ihit=0, PC_BRANCH branch_addr=0x100 pulsed once -> S_REDIR, imemaddr stays 0x20 until ihit; then pc=0x100, the 0x20 instruction is never valid in IF/ID.
- Same redirect case with a second redirect PC_JR jr_addr=0x200 before ihit -> pc becomes 0x200, not 0x100.
- flushed=1 with id_en=0 and IF/ID holding valid instr -> next cycle instr=0, valid=0; id_en=0 without flush -> IF/ID holds for the stalled cycles.
- halt=1 at pc=0x40 -> imemREN=0 next cycle, pc stays 0x40 indefinitely; nRST pulse mid-halt -> pc=PC_INIT, imemREN=1.
